// File: rtl/updown_counter_pkg.sv
// Shared types and parameter-legality helpers for the parametrised up/down counter.
package updown_counter_pkg;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } ovf_mode_e;

  function automatic ovf_mode_e mode_from_param(input int saturate);
    return (saturate != 0) ? SAT : WRAP;
  endfunction

  // Range checks use 64-bit math so that wide counters do not overflow the check itself.
  function automatic bit max_val_legal(input int width, input longint max_val);
    return (width >= 1) && (max_val >= 0) && (max_val <= ((longint'(1) << width) - 1));
  endfunction

  function automatic bit rst_val_legal(input longint rst_val, input longint max_val);
    return (rst_val >= 0) && (rst_val <= max_val);
  endfunction

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-count and boundary detection for updown_counter_n.
module updown_counter_next
  import updown_counter_pkg::*;
#(
  parameter int        WIDTH   = 3,
  parameter int        MAX_VAL = 2**WIDTH - 1,
  parameter ovf_mode_e MODE    = WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             step_up,
  input  logic             step_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             hit_max,
  output logic             hit_zero
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_C = '0;
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

  // Wrap is an explicit compare against MAX_C so non-power-of-two moduli behave.
  always_comb begin
    next_count = count;
    hit_max    = 1'b0;
    hit_zero   = 1'b0;
    if (load) begin
      next_count = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (step_up) begin
      if (count == MAX_C) begin
        hit_max    = 1'b1;
        next_count = (MODE == SAT) ? MAX_C : ZERO_C;
      end else begin
        next_count = count + ONE_C;
      end
    end else if (step_dn) begin
      if (count == ZERO_C) begin
        hit_zero   = 1'b1;
        next_count = (MODE == SAT) ? ZERO_C : MAX_C;
      end else begin
        next_count = count - ONE_C;
      end
    end
  end

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with load, enable, terminal-count pulses and sticky flags.
module updown_counter_n
  import updown_counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int SATURATE = 0,
  parameter int RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc_up,
  output logic             tc_down,
  output logic             ovf,
  output logic             unf,
  output logic             at_max,
  output logic             at_zero
);

  localparam ovf_mode_e        MODE    = mode_from_param(SATURATE);
  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C   = WIDTH'(RST_VAL);

  if (!max_val_legal(WIDTH, longint'(MAX_VAL))) begin : g_bad_max
    $fatal(1, "updown_counter_n: MAX_VAL must lie in 0..2**WIDTH-1");
  end
  if (!rst_val_legal(longint'(RST_VAL), longint'(MAX_VAL))) begin : g_bad_rst
    $fatal(1, "updown_counter_n: RST_VAL must lie in 0..MAX_VAL");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_up_q, tc_up_d;
  logic             tc_down_q, tc_down_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             step_up, step_dn;
  logic [WIDTH-1:0] next_count;
  logic             hit_max, hit_zero;

  // Simultaneous up and down cancel out; load always wins over stepping.
  assign step_up = en & up & ~down & ~load;
  assign step_dn = en & down & ~up & ~load;

  updown_counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .MODE    (MODE)
  ) u_next (
    .count      (count_q),
    .step_up    (step_up),
    .step_dn    (step_dn),
    .load       (load),
    .load_val   (load_val),
    .next_count (next_count),
    .hit_max    (hit_max),
    .hit_zero   (hit_zero)
  );

  // A boundary event in the same cycle as clr_flags keeps the flag set.
  always_comb begin
    count_d   = next_count;
    tc_up_d   = hit_max;
    tc_down_d = hit_zero;
    ovf_d     = hit_max | (ovf_q & ~clr_flags);
    unf_d     = hit_zero | (unf_q & ~clr_flags);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= RST_C;
      tc_up_q   <= 1'b0;
      tc_down_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      tc_up_q   <= tc_up_d;
      tc_down_q <= tc_down_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign count   = count_q;
  assign tc_up   = tc_up_q;
  assign tc_down = tc_down_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign at_max  = (count_q == MAX_C);
  assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_n.sv
// Drives three counter configurations (wrap, saturate, modulus 6) with shared stimulus and checks them against a model.
module tb_updown_counter_n;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       down;
  logic       load;
  logic [2:0] load_val;
  logic       clr_flags;

  logic [2:0] count_o   [3];
  logic       tc_up_o   [3];
  logic       tc_down_o [3];
  logic       ovf_o     [3];
  logic       unf_o     [3];
  logic       at_max_o  [3];
  logic       at_zero_o [3];

  int checks = 0;
  int errors = 0;

  // Instance 0: wrap, 0..7; instance 1: saturate, 0..7; instance 2: wrap, 0..5.
  int mx  [3] = '{7, 7, 5};
  bit sat [3] = '{1'b0, 1'b1, 1'b0};

  int m_cnt [3];
  bit m_tcu [3];
  bit m_tcd [3];
  bit m_ovf [3];
  bit m_unf [3];
  bit m_valid = 1'b0;

  updown_counter_n u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load),
    .load_val(load_val), .clr_flags(clr_flags),
    .count(count_o[0]), .tc_up(tc_up_o[0]), .tc_down(tc_down_o[0]),
    .ovf(ovf_o[0]), .unf(unf_o[0]), .at_max(at_max_o[0]), .at_zero(at_zero_o[0])
  );

  updown_counter_n #(.SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load),
    .load_val(load_val), .clr_flags(clr_flags),
    .count(count_o[1]), .tc_up(tc_up_o[1]), .tc_down(tc_down_o[1]),
    .ovf(ovf_o[1]), .unf(unf_o[1]), .at_max(at_max_o[1]), .at_zero(at_zero_o[1])
  );

  updown_counter_n #(.WIDTH(3), .MAX_VAL(5)) u_mod5 (
    .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load),
    .load_val(load_val), .clr_flags(clr_flags),
    .count(count_o[2]), .tc_up(tc_up_o[2]), .tc_down(tc_down_o[2]),
    .ovf(ovf_o[2]), .unf(unf_o[2]), .at_max(at_max_o[2]), .at_zero(at_zero_o[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: what each counter must hold after a clock edge, from the behavioural rules.
  always @(posedge clk) begin
    bit bu;
    bit bd;
    for (int i = 0; i < 3; i++) begin
      bu = 1'b0;
      bd = 1'b0;
      if (rst) begin
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
        m_unf[i] = 1'b0;
      end else begin
        if (load) begin
          m_cnt[i] = (int'(load_val) > mx[i]) ? mx[i] : int'(load_val);
        end else if (en && up && !down) begin
          if (m_cnt[i] == mx[i]) begin
            bu = 1'b1;
            m_cnt[i] = sat[i] ? mx[i] : 0;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end else if (en && down && !up) begin
          if (m_cnt[i] == 0) begin
            bd = 1'b1;
            m_cnt[i] = sat[i] ? 0 : mx[i];
          end else begin
            m_cnt[i] = m_cnt[i] - 1;
          end
        end
        if (clr_flags) begin
          m_ovf[i] = 1'b0;
          m_unf[i] = 1'b0;
        end
        if (bu) m_ovf[i] = 1'b1;
        if (bd) m_unf[i] = 1'b1;
      end
      m_tcu[i] = bu;
      m_tcd[i] = bd;
    end
    if (rst) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("model_count[%0d]", i), int'(count_o[i]), m_cnt[i]);
        checkOutput($sformatf("model_tc_up[%0d]", i), int'(tc_up_o[i]), int'(m_tcu[i]));
        checkOutput($sformatf("model_tc_down[%0d]", i), int'(tc_down_o[i]), int'(m_tcd[i]));
        checkOutput($sformatf("model_ovf[%0d]", i), int'(ovf_o[i]), int'(m_ovf[i]));
        checkOutput($sformatf("model_unf[%0d]", i), int'(unf_o[i]), int'(m_unf[i]));
        checkOutput($sformatf("model_at_max[%0d]", i), int'(at_max_o[i]), int'(m_cnt[i] == mx[i]));
        checkOutput($sformatf("model_at_zero[%0d]", i), int'(at_zero_o[i]), int'(m_cnt[i] == 0));
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit l, input bit e, input bit u,
                               input bit d, input bit c, input logic [2:0] lv);
    rst       = r;
    load      = l;
    en        = e;
    up        = u;
    down      = d;
    clr_flags = c;
    load_val  = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; down = 1'b0;
    clr_flags = 1'b0; load_val = 3'd0;
    @(posedge clk);
    #1;

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 0, 0, 3'd0);
    checkOutput("rst_count", int'(count_o[0]), 0);
    checkOutput("rst_ovf", int'(ovf_o[0]), 0);
    checkOutput("rst_at_zero", int'(at_zero_o[0]), 1);

    $display("[TB] count up through wrap");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, 1, 1, 0, 0, 3'd0);
      checkOutput("up_count", int'(count_o[0]), (i + 1) % 8);
      checkOutput("up_tc_up", int'(tc_up_o[0]), (i == 7) ? 1 : 0);
    end
    checkOutput("up_ovf", int'(ovf_o[0]), 1);
    checkOutput("up_sat_count", int'(count_o[1]), 7);
    checkOutput("up_mod5_count", int'(count_o[2]), 3);

    $display("[TB] count down through wrap, then clear flags");
    applyStimulus(0, 1, 0, 0, 0, 0, 3'd0);
    applyStimulus(0, 0, 1, 0, 1, 0, 3'd0);
    checkOutput("dn_count0", int'(count_o[0]), 7);
    checkOutput("dn_tc_down0", int'(tc_down_o[0]), 1);
    checkOutput("dn_mod5_count0", int'(count_o[2]), 5);
    applyStimulus(0, 0, 1, 0, 1, 0, 3'd0);
    checkOutput("dn_count1", int'(count_o[0]), 6);
    checkOutput("dn_tc_down1", int'(tc_down_o[0]), 0);
    checkOutput("dn_unf", int'(unf_o[0]), 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 3'd0);
    checkOutput("clr_unf", int'(unf_o[0]), 0);
    checkOutput("clr_ovf", int'(ovf_o[0]), 0);

    $display("[TB] saturate at max");
    applyStimulus(0, 1, 0, 0, 0, 0, 3'd7);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 1, 0, 0, 3'd0);
      checkOutput("sat_count", int'(count_o[1]), 7);
      checkOutput("sat_tc_up", int'(tc_up_o[1]), 1);
    end
    checkOutput("sat_ovf", int'(ovf_o[1]), 1);

    $display("[TB] non-power-of-two modulus");
    applyStimulus(0, 1, 0, 0, 0, 0, 3'd6);
    checkOutput("mod5_clamp", int'(count_o[2]), 5);
    checkOutput("mod5_at_max", int'(at_max_o[2]), 1);
    applyStimulus(0, 0, 1, 1, 0, 0, 3'd0);
    checkOutput("mod5_wrap_up", int'(count_o[2]), 0);
    checkOutput("mod5_tc_up", int'(tc_up_o[2]), 1);
    applyStimulus(0, 0, 1, 0, 1, 0, 3'd0);
    checkOutput("mod5_wrap_dn", int'(count_o[2]), 5);
    checkOutput("mod5_tc_down", int'(tc_down_o[2]), 1);

    $display("[TB] flag set beats clear");
    applyStimulus(0, 0, 0, 0, 0, 1, 3'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 3'd7);
    applyStimulus(0, 0, 1, 1, 0, 1, 3'd0);
    checkOutput("setwins_count", int'(count_o[0]), 0);
    checkOutput("setwins_ovf", int'(ovf_o[0]), 1);
    checkOutput("setwins_tc_up", int'(tc_up_o[0]), 1);

    $display("[TB] simultaneous controls");
    applyStimulus(0, 1, 0, 0, 0, 0, 3'd3);
    applyStimulus(0, 0, 1, 1, 1, 0, 3'd0);
    checkOutput("updown_hold", int'(count_o[0]), 3);
    checkOutput("updown_tc_up", int'(tc_up_o[0]), 0);
    checkOutput("updown_tc_down", int'(tc_down_o[0]), 0);
    applyStimulus(0, 1, 1, 1, 0, 0, 3'd2);
    checkOutput("load_over_up", int'(count_o[0]), 2);
    applyStimulus(0, 0, 0, 1, 0, 0, 3'd0);
    checkOutput("en_off_hold", int'(count_o[0]), 2);

    $display("[TB] reset mid-operation");
    applyStimulus(0, 1, 0, 0, 0, 0, 3'd3);
    applyStimulus(0, 0, 1, 1, 0, 0, 3'd0);
    checkOutput("pre_rst_count", int'(count_o[0]), 4);
    applyStimulus(1, 1, 1, 1, 0, 0, 3'd5);
    checkOutput("mid_rst_count", int'(count_o[0]), 0);
    checkOutput("mid_rst_ovf", int'(ovf_o[0]), 0);
    checkOutput("mid_rst_unf", int'(unf_o[0]), 0);
    checkOutput("mid_rst_tc_up", int'(tc_up_o[0]), 0);
    checkOutput("mid_rst_tc_down", int'(tc_down_o[0]), 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 3'd0);
    checkOutput("post_rst_count", int'(count_o[0]), 1);

    applyStimulus(0, 0, 0, 0, 0, 0, 3'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
